arcade_loader: RTL and testbench

ARCADE_LOADER -- requirements
Module: arcade_loader

---
 rtl/arcade_loader.sv | 139 +++++++++++++
 tb/tb_arcade_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_loader.sv
// HPS download sink for an arcade core: routes ROM bytes to a write port,
// captures machine-select and DIP bytes, and holds the core in reset around downloads.
module arcade_loader #(
    parameter int HOLD_CYCLES = 16,
    parameter int ROM_BYTES   = 16384
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        rom_wr,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [7:0]  mod,
    output logic [63:0] sw,
    output logic        core_reset,
    output logic [16:0] rom_count,
    output logic        rom_err
);
    localparam int              HW      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0]   LP_HEND = HW'(HOLD_CYCLES - 1);
    localparam logic [24:0]     LP_LIM  = 25'(ROM_BYTES);
    localparam logic [16:0]     LP_SAT  = 17'(ROM_BYTES);

    typedef enum logic [2:0] {S_IDLE, S_ROM, S_MOD, S_DIP, S_HOLD} state_t;

    state_t        r_state, w_next, w_entry;
    logic          r_dl_d;
    logic [7:0]    r_idx;
    logic          r_ign;
    logic [HW-1:0] r_hold;
    logic          r_rom_wr;
    logic [15:0]   r_rom_addr;
    logic [7:0]    r_rom_data;
    logic [7:0]    r_mod;
    logic [63:0]   r_sw;
    logic [16:0]   r_rom_count;
    logic          r_rom_err;

    logic w_rise, w_fall, w_xfer, w_idx_chg, w_byte, w_enter, w_ign;

    assign w_rise    = ioctl_download & ~r_dl_d;
    assign w_fall    = ~ioctl_download & r_dl_d;
    assign w_xfer    = (r_state == S_ROM) || (r_state == S_MOD) || (r_state == S_DIP);
    assign w_idx_chg = w_xfer && ioctl_download && (ioctl_index != r_idx);
    // A byte arriving with a changed index belongs to no valid transfer; drop it.
    assign w_byte    = w_xfer && ioctl_wr && !w_idx_chg;
    assign w_enter   = w_rise && ((r_state == S_IDLE) || (r_state == S_HOLD));
    assign w_ign     = (ioctl_index != 8'd0) && (ioctl_index != 8'd1) && (ioctl_index != 8'd254);

    always_comb begin
        w_entry = S_DIP;
        if (ioctl_index == 8'd0)
            w_entry = S_ROM;
        else if (ioctl_index == 8'd1)
            w_entry = S_MOD;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_rise) w_next = w_entry;
            S_ROM, S_MOD, S_DIP: if (w_idx_chg || w_fall) w_next = S_HOLD;
            S_HOLD: begin
                if (w_rise)
                    w_next = w_entry;
                else if (r_hold == LP_HEND)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= S_IDLE;
            // Track the strobe through reset so a transfer still in flight is not re-entered.
            r_dl_d      <= ioctl_download;
            r_idx       <= 8'd0;
            r_ign       <= 1'b0;
            r_hold      <= '0;
            r_rom_wr    <= 1'b0;
            r_rom_addr  <= 16'd0;
            r_rom_data  <= 8'd0;
            r_mod       <= 8'd0;
            r_sw        <= {64{1'b1}};
            r_rom_count <= 17'd0;
            r_rom_err   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_dl_d   <= ioctl_download;
            r_rom_wr <= 1'b0;
            r_hold   <= (r_state == S_HOLD && w_next == S_HOLD) ? r_hold + 1'b1 : '0;

            if (w_enter) begin
                r_idx <= ioctl_index;
                r_ign <= w_ign;
                if (ioctl_index == 8'd0) begin
                    r_rom_count <= 17'd0;
                    r_rom_err   <= 1'b0;
                end
            end

            if (w_idx_chg)
                r_rom_err <= 1'b1;

            if (r_state == S_ROM && w_byte) begin
                if (ioctl_addr < LP_LIM) begin
                    r_rom_wr    <= 1'b1;
                    r_rom_addr  <= ioctl_addr[15:0];
                    r_rom_data  <= ioctl_dout;
                    r_rom_count <= (r_rom_count == LP_SAT) ? r_rom_count : r_rom_count + 17'd1;
                    if (ioctl_addr != {8'd0, r_rom_count})
                        r_rom_err <= 1'b1;
                end else begin
                    r_rom_err <= 1'b1;
                end
            end

            if (r_state == S_MOD && w_byte)
                r_mod <= ioctl_dout;

            if (r_state == S_DIP && w_byte && !r_ign && ioctl_addr[24:3] == 22'd0)
                r_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
    end

    assign rom_wr     = r_rom_wr;
    assign rom_addr   = r_rom_addr;
    assign rom_data   = r_rom_data;
    assign mod        = r_mod;
    assign sw         = r_sw;
    assign rom_count  = r_rom_count;
    assign rom_err    = r_rom_err;
    assign core_reset = reset || (r_state != S_IDLE) || w_rise;
endmodule

// File: tb/tb_arcade_loader.sv
// Directed + randomized bench for arcade_loader; a second instance with ROM_BYTES=4
// shares the stimulus and is checked on the overflow scenario.
module tb_arcade_loader;
    localparam int HOLD = 16;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;

    logic        a_rom_wr, b_rom_wr, a_core_reset, b_core_reset, a_rom_err, b_rom_err;
    logic [15:0] a_rom_addr, b_rom_addr;
    logic [7:0]  a_rom_data, b_rom_data, a_mod, b_mod;
    logic [63:0] a_sw, b_sw;
    logic [16:0] a_rom_count, b_rom_count;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_mod;
    logic [7:0] m_sw [8];

    arcade_loader #(.HOLD_CYCLES(HOLD), .ROM_BYTES(16384)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .rom_wr(a_rom_wr), .rom_addr(a_rom_addr), .rom_data(a_rom_data), .mod(a_mod), .sw(a_sw),
        .core_reset(a_core_reset), .rom_count(a_rom_count), .rom_err(a_rom_err));

    arcade_loader #(.HOLD_CYCLES(HOLD), .ROM_BYTES(4)) dut4 (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .rom_wr(b_rom_wr), .rom_addr(b_rom_addr), .rom_data(b_rom_data), .mod(b_mod), .sw(b_sw),
        .core_reset(b_core_reset), .rom_count(b_rom_count), .rom_err(b_rom_err));

    always #5 clk_sys = ~clk_sys;

    function automatic logic [63:0] sw_model();
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = m_sw[k];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_xfer(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        #1;
        chk("core_reset_on_rise", a_core_reset, 1'b1);
        step();
    endtask

    // Drive one byte; the main ROM port must echo it on the next cycle when expected.
    task automatic put_byte(input logic [24:0] addr, input logic [7:0] d, input logic exp_wr, input string tag);
        ioctl_wr   = 1'b1;
        ioctl_addr = addr;
        ioctl_dout = d;
        step();
        ioctl_wr = 1'b0;
        chk({tag, "_wr"}, a_rom_wr, exp_wr);
        if (exp_wr) begin
            chk({tag, "_addr"}, a_rom_addr, addr[15:0]);
            chk({tag, "_data"}, a_rom_data, d);
        end
    endtask

    // Drop download and count how long core_reset persists afterwards.
    task automatic end_xfer(input string tag);
        int n;
        ioctl_download = 1'b0;
        n = 0;
        for (int i = 0; i < 3 * HOLD; i++) begin
            step();
            if (a_core_reset) n++;
            else break;
        end
        chk(tag, n, HOLD);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (a_core_reset && n < 4 * HOLD) begin
            step();
            n++;
        end
        chk(tag, a_core_reset, 1'b0);
    endtask

    initial begin
        logic [7:0] bytes [4];
        logic [7:0] r;
        int nrand;
        bytes[0] = 8'hA5; bytes[1] = 8'h5A; bytes[2] = 8'h00; bytes[3] = 8'hFF;
        m_mod = 8'h00;
        for (int k = 0; k < 8; k++) m_sw[k] = 8'hFF;

        // Reset state
        step(); step();
        chk("rst_core_reset", a_core_reset, 1'b1);
        chk("rst_rom_wr", a_rom_wr, 1'b0);
        chk("rst_rom_addr", a_rom_addr, 16'd0);
        chk("rst_rom_data", a_rom_data, 8'd0);
        chk("rst_rom_count", a_rom_count, 17'd0);
        chk("rst_rom_err", a_rom_err, 1'b0);
        chk("rst_mod", a_mod, 8'd0);
        chk("rst_sw", a_sw, sw_model());
        reset = 1'b0;
        step();
        chk("idle_core_reset", a_core_reset, 1'b0);

        // Fixed ROM pattern
        start_xfer(8'd0);
        for (int i = 0; i < 4; i++) put_byte(25'(i), bytes[i], 1'b1, "rom4");
        step();
        chk("rom4_gap_wr", a_rom_wr, 1'b0);
        chk("rom4_count", a_rom_count, 17'd4);
        chk("rom4_err", a_rom_err, 1'b0);
        end_xfer("rom4_hold_len");

        // Random-length, random-data ROM
        nrand = $urandom_range(5, 12);
        start_xfer(8'd0);
        for (int i = 0; i < nrand; i++) put_byte(25'(i), 8'($urandom), 1'b1, "romrnd");
        chk("romrnd_count", a_rom_count, 17'(nrand));
        chk("romrnd_err", a_rom_err, 1'b0);
        chk("romrnd_small_count", b_rom_count, 17'd4);
        chk("romrnd_small_err", b_rom_err, 1'b1);
        end_xfer("romrnd_hold_len");

        // Overflow against the 4-byte instance
        start_xfer(8'd0);
        chk("ovf_count_clr", b_rom_count, 17'd0);
        chk("ovf_err_clr", b_rom_err, 1'b0);
        for (int i = 0; i < 5; i++) begin
            put_byte(25'(i), 8'($urandom), 1'b1, "ovf_big");
            chk("ovf_small_wr", b_rom_wr, (i < 4) ? 1'b1 : 1'b0);
        end
        chk("ovf_small_count", b_rom_count, 17'd4);
        chk("ovf_small_err", b_rom_err, 1'b1);
        chk("ovf_big_count", a_rom_count, 17'd5);
        end_xfer("ovf_hold_len");

        // Non-sequential and out-of-range bytes
        start_xfer(8'd0);
        put_byte(25'd0, 8'h11, 1'b1, "nseq0");
        put_byte(25'd2, 8'h22, 1'b1, "nseq2");
        chk("nseq_err", a_rom_err, 1'b1);
        put_byte(25'd20000, 8'h33, 1'b0, "oor");
        chk("oor_count", a_rom_count, 17'd2);
        end_xfer("nseq_hold_len");

        // Machine select, then a ROM transfer must not disturb it
        start_xfer(8'd1);
        put_byte(25'd0, 8'h03, 1'b0, "mod_a");
        put_byte(25'd5, 8'h07, 1'b0, "mod_b");
        m_mod = 8'h07;
        chk("mod_val", a_mod, m_mod);
        end_xfer("mod_hold_len");
        start_xfer(8'd0);
        put_byte(25'd0, 8'h99, 1'b1, "mod_rom");
        end_xfer("mod_rom_hold_len");
        chk("mod_persist", a_mod, m_mod);

        // DIP bank plus one random in-range byte
        start_xfer(8'd254);
        put_byte(25'd2, 8'h3C, 1'b0, "dip2");
        m_sw[2] = 8'h3C;
        put_byte(25'd9, 8'h11, 1'b0, "dip9");
        r = 8'($urandom);
        put_byte(25'd6, r, 1'b0, "dip6");
        m_sw[6] = r;
        chk("dip_sw", a_sw, sw_model());
        end_xfer("dip_hold_len");

        // Unknown index: DIP path that writes nothing
        start_xfer(8'd7);
        put_byte(25'd0, 8'h55, 1'b0, "ign");
        chk("ign_core_reset", a_core_reset, 1'b1);
        end_xfer("ign_hold_len");
        chk("ign_sw", a_sw, sw_model());
        chk("ign_mod", a_mod, m_mod);

        // Bytes while idle are dropped
        put_byte(25'd0, 8'h77, 1'b0, "idle_byte");
        chk("idle_mod", a_mod, m_mod);

        // Restart five cycles into HOLD
        start_xfer(8'd0);
        for (int i = 0; i < 3; i++) put_byte(25'(i), 8'($urandom), 1'b1, "rs");
        ioctl_download = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rs_hold_core_reset", a_core_reset, 1'b1);
        end
        chk("rs_count_before", a_rom_count, 17'd3);
        start_xfer(8'd0);
        chk("rs_count_clr", a_rom_count, 17'd0);
        put_byte(25'd0, 8'h5E, 1'b1, "rs_new");
        chk("rs_new_count", a_rom_count, 17'd1);
        end_xfer("rs_hold_len");

        // Index change mid-transfer
        start_xfer(8'd0);
        put_byte(25'd0, 8'h01, 1'b1, "ichg");
        ioctl_index = 8'd1;
        step();
        chk("ichg_err", a_rom_err, 1'b1);
        chk("ichg_core_reset", a_core_reset, 1'b1);
        ioctl_download = 1'b0;
        wait_idle("ichg_idle");

        // Byte coincident with falling edge is still taken
        start_xfer(8'd1);
        r = 8'($urandom);
        ioctl_download = 1'b0;
        put_byte(25'd0, r, 1'b0, "fall_mod");
        m_mod = r;
        chk("fall_mod_val", a_mod, m_mod);
        wait_idle("fall_mod_idle");
        start_xfer(8'd0);
        ioctl_download = 1'b0;
        put_byte(25'd0, 8'hC3, 1'b1, "fall_rom");
        chk("fall_rom_count", a_rom_count, 17'd1);
        wait_idle("fall_rom_idle");

        // Reset mid-transfer
        start_xfer(8'd0);
        put_byte(25'd0, 8'hAA, 1'b1, "abort0");
        put_byte(25'd1, 8'hBB, 1'b1, "abort1");
        reset = 1'b1;
        step();
        chk("abort_rst_core_reset", a_core_reset, 1'b1);
        reset = 1'b0;
        step();
        put_byte(25'd2, 8'hCC, 1'b0, "abort2");
        put_byte(25'd3, 8'hDD, 1'b0, "abort3");
        chk("abort_core_reset", a_core_reset, 1'b0);
        chk("abort_err", a_rom_err, 1'b0);
        chk("abort_sw_keep", a_sw, {64{1'b1}});
        ioctl_download = 1'b0;
        step();
        chk("abort_idle", a_core_reset, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
